// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one synchronous single-port memory between
// the fetch path and the load/store path of the miniRV core.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   if_req/if_addr        fetch request (held until if_valid)
//   if_valid/if_rdata     fetch response pulse and instruction word
//   d_req/d_we/d_addr     data request (held until d_valid)
//   d_wdata/d_wstrb       store data and byte enables
//   d_valid/d_rdata       data response pulse and load word
//   mem_*                 memory side: strobe, write, word index, data
//   busy                  high whenever a transaction is in flight
module imem_port_arbiter #(
    parameter int ADDR_WIDTH   = 24,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [3:0]            d_wstrb,
    output logic                  d_valid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic [1:0] {G_NONE, G_IF, G_D} gnt_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    state_t                state_q, state_d;
    gnt_t                  gnt_q, gnt_d;
    logic [3:0]            starve_q, starve_d;
    logic [ADDR_WIDTH-3:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;

    logic decide;
    logic if_cand;
    logic d_cand;
    logic pick_if;
    logic pick_d;

    // Byte-offset bits never reach the word-organised memory.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= G_NONE;
            starve_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        decide   = 1'b0;
        if_cand  = 1'b0;
        d_cand   = 1'b0;
        pick_if  = 1'b0;
        pick_d   = 1'b0;

        case (state_q)
            IDLE: begin
                decide  = 1'b1;
                if_cand = if_req;
                d_cand  = d_req;
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                // Hand off to the other side; the served side's req is
                // still its old request and must not win again here.
                decide  = 1'b1;
                if_cand = if_req && (gnt_q == G_D);
                d_cand  = d_req && (gnt_q == G_IF);
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (decide) begin
            pick_if = if_cand && (!d_cand || (starve_q == LIM));
            pick_d  = d_cand && !pick_if;
        end

        if (pick_if) begin
            state_d  = ISSUE;
            gnt_d    = G_IF;
            starve_d = '0;
            addr_d   = if_addr[ADDR_WIDTH-1:2];
            we_d     = 1'b0;
            wdata_d  = '0;
            wstrb_d  = '0;
        end else if (pick_d) begin
            state_d = ISSUE;
            gnt_d   = G_D;
            addr_d  = d_addr[ADDR_WIDTH-1:2];
            we_d    = d_we;
            wdata_d = d_wdata;
            wstrb_d = d_wstrb;
            if (if_cand && (starve_q != LIM)) begin
                starve_d = starve_q + 4'd1;
            end
        end else if (decide) begin
            state_d = IDLE;
            gnt_d   = G_NONE;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if_valid  = 1'b0;
        if_rdata  = '0;
        d_valid   = 1'b0;
        d_rdata   = '0;
        busy      = (state_q != IDLE);

        if (state_q == ISSUE) begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_wstrb = we_q ? wstrb_q : 4'b0000;
        end

        if (state_q == RESP) begin
            if (gnt_q == G_IF) begin
                if_valid = 1'b1;
                if_rdata = mem_rdata;
            end
            if (gnt_q == G_D) begin
                d_valid = 1'b1;
                if (!we_q) begin
                    d_rdata = mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: scoreboard bench for imem_port_arbiter with a
// small behavioural synchronous memory on the memory port.
module tb_imem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [23:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [23:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [21:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        busy;

    imem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:255];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) begin
                        mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
                    end
                end
            end
            mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_valid(input logic want_d, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            seen = want_d ? d_valid : if_valid;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    // Every response is matched against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (if_valid || d_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("valid_port", 64'({if_valid, d_valid}),
                    e.is_d ? 64'd1 : 64'd2);
                chk("rdata", 64'(e.is_d ? d_rdata : if_rdata),
                    64'(e.data));
            end
        end
    end

    int n;
    int last;
    int cnt;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        mem[2]  = 32'h0050_0093;
        mem[8]  = 32'h1111_0008;
        mem[9]  = 32'h2222_0009;
        mem[12] = 32'h3333_000C;
        mem_rdata = '0;
        rst     = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        d_wstrb = '0;

        repeat (3) @(negedge clk);
        chk("rst_outs", 64'({busy, mem_en, mem_we, if_valid, d_valid,
                             mem_wstrb, mem_addr}), 64'd0);
        rst = 1'b0;

        // Single fetch: timing from request to valid and back to idle.
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 24'h000008;
        push(1'b0, 32'h0050_0093);
        @(negedge clk);
        chk("f1_mem_en", 64'(mem_en), 64'd1);
        chk("f1_mem_addr", 64'(mem_addr), 64'd2);
        chk("f1_mem_we", 64'(mem_we), 64'd0);
        @(negedge clk);
        chk("f1_valid_c2", 64'(if_valid), 64'd1);
        if_req = 1'b0;
        @(negedge clk);
        chk("f1_idle_c3", 64'(busy), 64'd0);

        // Store then load back the same word.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 24'h000010;
        d_wdata = 32'hDEAD_BEEF;
        d_wstrb = 4'hF;
        push(1'b1, 32'h0);
        @(negedge clk);
        chk("wr_mem_we", 64'(mem_we), 64'd1);
        chk("wr_mem_addr", 64'(mem_addr), 64'd4);
        chk("wr_mem_wstrb", 64'(mem_wstrb), 64'hF);
        chk("wr_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        wait_valid(1'b1, "wr_dvalid");
        d_we    = 1'b0;
        d_wstrb = 4'h0;
        push(1'b1, 32'hDEAD_BEEF);
        wait_valid(1'b1, "rd_dvalid");
        d_req = 1'b0;
        @(negedge clk);

        // Both requesters held: strict D,F alternation every 2 cycles.
        for (int k = 0; k < 4; k++) begin
            push(1'b1, 32'h2222_0009);
            push(1'b0, 32'h1111_0008);
        end
        if_req  = 1'b1;
        if_addr = 24'h000020;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 24'h000024;
        n = 0;
        last = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(negedge clk);
            if (if_valid || d_valid) begin
                if (n > 0) chk("alt_spacing", 64'(c - last), 64'd2);
                last = c;
                n++;
                if (n == 8) begin
                    if_req = 1'b0;
                    d_req  = 1'b0;
                end
            end
        end
        chk("alt_count", 64'(n), 64'd8);
        @(negedge clk);

        // Four contested IDLE losses by fetch, then fetch is forced.
        for (int k = 0; k < 4; k++) begin
            if_req = 1'b1;
            d_req  = 1'b1;
            push(1'b1, 32'h2222_0009);
            @(negedge clk);
            chk("stv_win_d", 64'(mem_addr), 64'd9);
            if_req = 1'b0;
            wait_valid(1'b1, "stv_dvalid");
            d_req = 1'b0;
            @(negedge clk);
        end
        if_req = 1'b1;
        d_req  = 1'b1;
        push(1'b0, 32'h1111_0008);
        @(negedge clk);
        chk("stv_win_f", 64'(mem_addr), 64'd8);
        d_req = 1'b0;
        wait_valid(1'b0, "stv_ivalid");
        if_req = 1'b0;
        @(negedge clk);
        // Counter cleared: data wins the next contested decision.
        if_req = 1'b1;
        d_req  = 1'b1;
        push(1'b1, 32'h2222_0009);
        @(negedge clk);
        chk("stv_cleared", 64'(mem_addr), 64'd9);
        if_req = 1'b0;
        wait_valid(1'b1, "stv_dvalid2");
        d_req = 1'b0;
        @(negedge clk);

        // Fetch dropped in ISSUE still completes; top-of-space wrap.
        if_req  = 1'b1;
        if_addr = 24'hFFFFFC;
        push(1'b0, 32'hA500_00FF);
        @(negedge clk);
        chk("drop_mem_en", 64'(mem_en), 64'd1);
        chk("wrap_addr", 64'(mem_addr), 64'h3F_FFFF);
        if_req = 1'b0;
        wait_valid(1'b0, "drop_ivalid");
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_en) cnt++;
        end
        chk("drop_no_mem_en", 64'(cnt), 64'd0);

        // Reset in the middle of a write ISSUE.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 24'h000030;
        d_wdata = 32'hCAFE_F00D;
        d_wstrb = 4'hF;
        @(negedge clk);
        chk("rw_issue", 64'({mem_en, mem_we}), 64'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("rw_async", 64'({mem_en, mem_we, busy}), 64'd0);
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (d_valid || if_valid) cnt++;
        end
        chk("rw_no_valid", 64'(cnt), 64'd0);
        chk("rw_mem_kept", 64'(mem[12]), 64'h3333_000C);
        chk("rw_idle", 64'(busy), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
